// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the async FIFO.
// Covers pointer Gray/binary conversion, address-width derivation and the read-side state encoding.
package fifo_pkg;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Operates on zero-extended pointers; callers truncate back to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ptr_sync.sv
// Multi-bit flop synchronizer for Gray-coded FIFO pointers crossing clock domains.
module ptr_sync #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO.
// Owns the read pointer, empty/count flags and the first-word-fall-through output stage.
//
// state    | meaning
// RD_IDLE  | no unconsumed word on dout
// RD_VALID | dout holds a fetched word awaiting dout_ready
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 4,
    localparam int AW           = addr_width(DEPTH)
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic [AW:0]      wr_ptr_gray,
    output logic [AW:0]      rd_ptr_gray,
    output logic [AW:0]      rd_ptr,
    output logic             mem_rd_en,
    output logic             empty,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             flush,
    output logic [AW:0]      rd_count,
    output logic             almost_empty
);

    localparam int PW = AW + 1;
    localparam logic [AW:0] THRESH = PW'(AEMPTY_THRESH);

    logic [AW:0] wq_gray, wq_bin;
    logic [AW:0] rd_ptr_q, rd_ptr_d, rd_gray_q, rd_gray_d;
    logic [AW:0] rd_ptr_next, count_next;
    logic [AW:0] rd_count_q, rd_count_d;
    logic        empty_q, empty_d, aempty_q, aempty_d;
    logic        rd_en;
    rd_state_e   state_q, state_d;

    ptr_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i   (rd_clk),
        .rst_n_i (rd_rst_n),
        .d_i     (wr_ptr_gray),
        .q_o     (wq_gray)
    );

    assign wq_bin      = PW'(gray2bin(32'(wq_gray)));
    assign rd_en       = ~empty_q & ((state_q == RD_IDLE) | dout_ready) & ~flush;
    assign rd_ptr_next = rd_ptr_q + {{AW{1'b0}}, rd_en};
    assign count_next  = wq_bin - rd_ptr_next;

    // Flush jumps to the already-synchronized write pointer, so later writes survive.
    always_comb begin
        rd_ptr_d   = rd_ptr_next;
        rd_gray_d  = PW'(bin2gray(32'(rd_ptr_next)));
        empty_d    = (rd_gray_d == wq_gray);
        rd_count_d = count_next;
        aempty_d   = (count_next <= THRESH);
        if (flush) begin
            rd_ptr_d   = wq_bin;
            rd_gray_d  = wq_gray;
            empty_d    = 1'b1;
            rd_count_d = '0;
            aempty_d   = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_q   <= '0;
            rd_gray_q  <= '0;
            empty_q    <= 1'b1;
            rd_count_q <= '0;
            aempty_q   <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_gray_q  <= rd_gray_d;
            empty_q    <= empty_d;
            rd_count_q <= rd_count_d;
            aempty_q   <= aempty_d;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:  if (rd_en) state_d = RD_VALID;
            RD_VALID: if (dout_ready && !rd_en) state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
        if (flush) state_d = RD_IDLE;
    end

    always_comb begin
        dout_valid = (state_q == RD_VALID);
    end

    assign mem_rd_en    = rd_en;
    assign dout         = mem_rd_data;
    assign rd_ptr       = rd_ptr_q;
    assign rd_ptr_gray  = rd_gray_q;
    assign empty        = empty_q;
    assign rd_count     = rd_count_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural FIFO memory and write side.
module tb_fifo_rd_ctrl;

    logic       rd_clk;
    logic       rd_rst_n;
    logic [5:0] wr_ptr_gray;
    logic [5:0] rd_ptr_gray;
    logic [5:0] rd_ptr;
    logic       mem_rd_en;
    logic       empty;
    logic [7:0] mem_rd_data;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       flush;
    logic [5:0] rd_count;
    logic       almost_empty;

    logic [7:0] mem [32];
    logic [5:0] wbin;
    int checks;
    int failures;

    fifo_rd_ctrl #(
        .WIDTH(8), .DEPTH(32), .SYNC_STAGES(2), .AEMPTY_THRESH(4)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .rd_ptr       (rd_ptr),
        .mem_rd_en    (mem_rd_en),
        .empty        (empty),
        .mem_rd_data  (mem_rd_data),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .flush        (flush),
        .rd_count     (rd_count),
        .almost_empty (almost_empty)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= mem[rd_ptr[4:0]];
    end

    function automatic logic [5:0] g(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wbin[4:0]] = d;
        wbin = wbin + 6'd1;
        wr_ptr_gray = g(wbin);
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0;
        wbin = '0;
        wr_ptr_gray = '0;
        dout_ready = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        rd_rst_n = 1'b1;
        tick();
        checks++;
        if (empty !== 1'b1 || dout_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags empty=%b valid=%b rden=%b exp 1/0/0", empty, dout_valid, mem_rd_en);
        end
        checks++;
        if (rd_ptr !== 6'd0 || rd_ptr_gray !== 6'd0 || rd_count !== 6'd0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_regs ptr=%0d gray=%0h cnt=%0d ae=%b exp 0/0/0/1", rd_ptr, rd_ptr_gray, rd_count, almost_empty);
        end
    endtask

    task automatic test_single_word();
        push(8'hA5);
        tick();
        tick();
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty_early got=%b exp=1", empty);
        end
        tick();
        checks++;
        if (empty !== 1'b0 || rd_count !== 6'd1 || almost_empty !== 1'b1 || mem_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL single_empty_fall empty=%b cnt=%0d ae=%b rden=%b exp 0/1/1/1", empty, rd_count, almost_empty, mem_rd_en);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5 || empty !== 1'b1 || rd_ptr !== 6'd1 || rd_count !== 6'd0) begin
            failures++;
            $display("FAIL single_valid valid=%b dout=%0h empty=%b ptr=%0d cnt=%0d exp 1/a5/1/1/0", dout_valid, dout, empty, rd_ptr, rd_count);
        end
        dout_ready = 1'b1;
        tick();
        checks++;
        if (dout_valid !== 1'b0 || empty !== 1'b1 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL single_consume valid=%b empty=%b rden=%b exp 0/1/0", dout_valid, empty, mem_rd_en);
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_stream();
        int got = 0;
        int first = -1;
        int last = -1;
        int exp_cnt = 0;
        bit seen32 = 1'b0;
        for (int i = 0; i < 32; i++) push(8'(8'h10 + i));
        dout_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            tick();
            if (dout_valid) begin
                checks++;
                if (dout !== 8'(8'h10 + got)) begin
                    failures++;
                    $display("FAIL stream_data idx=%0d got=%0h exp=%0h", got, dout, 8'(8'h10 + got));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (!seen32 && rd_count == 6'd32) begin
                seen32 = 1'b1;
                exp_cnt = 32;
            end else if (seen32) begin
                if (exp_cnt > 0) exp_cnt--;
                checks++;
                if (rd_count !== 6'(exp_cnt) || almost_empty !== (exp_cnt <= 4)) begin
                    failures++;
                    $display("FAIL stream_count got=%0d ae=%b exp=%0d ae=%b", rd_count, almost_empty, exp_cnt, exp_cnt <= 4);
                end
            end
        end
        checks++;
        if (!seen32 || got != 32 || (last - first + 1) != 32) begin
            failures++;
            $display("FAIL stream_throughput seen32=%b words=%0d span=%0d exp 1/32/32", seen32, got, last - first + 1);
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        repeat (4) tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h60 || rd_ptr !== 6'd34) begin
            failures++;
            $display("FAIL bp_first valid=%b dout=%0h ptr=%0d exp 1/60/34", dout_valid, dout, rd_ptr);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dout !== 8'h60 || dout_valid !== 1'b1 || mem_rd_en !== 1'b0 || rd_ptr !== 6'd34) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d dout=%0h valid=%b rden=%b ptr=%0d exp 60/1/0/34", i, dout, dout_valid, mem_rd_en, rd_ptr);
            end
        end
        dout_ready = 1'b1;
        #1;
        checks++;
        if (mem_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_rden got=%b exp=1", mem_rd_en);
        end
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== 8'(8'h60 + k)) begin
                failures++;
                $display("FAIL bp_drain k=%0d valid=%b dout=%0h exp 1/%0h", k, dout_valid, dout, 8'(8'h60 + k));
            end
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || empty !== 1'b1 || rd_ptr !== 6'd38) begin
            failures++;
            $display("FAIL bp_end valid=%b empty=%b ptr=%0d exp 0/1/38", dout_valid, empty, rd_ptr);
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int wrote = 0;
        int got = 0;
        int wraps = 0;
        logic [5:0] prev_g;
        logic [5:0] prev_b;
        logic [5:0] diff;
        prev_g = rd_ptr_gray;
        prev_b = rd_ptr;
        dout_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            tick();
            if (dout_valid) begin
                checks++;
                if (dout !== 8'(got * 7 + 3)) begin
                    failures++;
                    $display("FAIL wrap_data idx=%0d got=%0h exp=%0h", got, dout, 8'(got * 7 + 3));
                end
                got++;
            end
            if (rd_ptr_gray !== prev_g) begin
                checks++;
                if ($countones(rd_ptr_gray ^ prev_g) != 1 || rd_ptr_gray !== g(rd_ptr)) begin
                    failures++;
                    $display("FAIL wrap_gray prev=%0h got=%0h exp=%0h", prev_g, rd_ptr_gray, g(rd_ptr));
                end
            end
            if (prev_b == 6'd63 && rd_ptr == 6'd0) wraps++;
            prev_g = rd_ptr_gray;
            prev_b = rd_ptr;
            diff = wbin - rd_ptr;
            if (wrote < 100 && diff < 6'd31) begin
                push(8'(wrote * 7 + 3));
                wrote++;
            end
        end
        repeat (2) tick();
        checks++;
        if (got != 100 || wraps < 1 || rd_ptr !== 6'd10 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_summary words=%0d wraps=%0d ptr=%0d valid=%b exp 100/>=1/10/0", got, wraps, rd_ptr, dout_valid);
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        repeat (4) tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h80 || rd_count !== 6'd7) begin
            failures++;
            $display("FAIL flush_pre valid=%b dout=%0h cnt=%0d exp 1/80/7", dout_valid, dout, rd_count);
        end
        flush = 1'b1;
        dout_ready = 1'b1;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_rden got=%b exp=0", mem_rd_en);
        end
        tick();
        flush = 1'b0;
        dout_ready = 1'b0;
        checks++;
        if (rd_ptr !== wbin || rd_ptr_gray !== g(wbin) || empty !== 1'b1 || dout_valid !== 1'b0
            || rd_count !== 6'd0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_state ptr=%0d gray=%0h empty=%b valid=%b cnt=%0d ae=%b exp %0d/%0h/1/0/0/1",
                     rd_ptr, rd_ptr_gray, empty, dout_valid, rd_count, almost_empty, wbin, g(wbin));
        end
        repeat (3) tick();
        checks++;
        if (empty !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stays_empty empty=%b valid=%b exp 1/0", empty, dout_valid);
        end
        push(8'hC3);
        repeat (4) tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'hC3) begin
            failures++;
            $display("FAIL flush_after_write valid=%b dout=%0h exp 1/c3", dout_valid, dout);
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_after_consume valid=%b empty=%b exp 0/1", dout_valid, empty);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) push(8'(8'hD0 + i));
        repeat (4) tick();
        checks++;
        if (dout_valid !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre valid=%b empty=%b exp 1/0", dout_valid, empty);
        end
        #2;
        rd_rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || dout_valid !== 1'b0 || rd_ptr !== 6'd0 || rd_count !== 6'd0
            || almost_empty !== 1'b1 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async empty=%b valid=%b ptr=%0d cnt=%0d ae=%b rden=%b exp 1/0/0/0/1/0",
                     empty, dout_valid, rd_ptr, rd_count, almost_empty, mem_rd_en);
        end
        wbin = '0;
        wr_ptr_gray = '0;
        tick();
        rd_rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (empty !== 1'b1 || dout_valid !== 1'b0 || rd_ptr_gray !== 6'd0) begin
            failures++;
            $display("FAIL midrst_after empty=%b valid=%b gray=%0h exp 1/0/0", empty, dout_valid, rd_ptr_gray);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rd_rst_n = 1'b0;
        wbin = '0;
        wr_ptr_gray = '0;
        dout_ready = 1'b0;
        flush = 1'b0;
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain. It pairs with the dual-port FIFO memory and the write-side pointer logic. It synchronizes the write pointer (Gray-coded) into `rd_clk`, and maintains the binary/Gray read pointer, the empty flag, the fill count and the almost-empty flag. It drives the memory's synchronous read port and presents data to the consumer as a first-word-fall-through valid/ready stream.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `DEPTH`, 32: FIFO depth. Power of two. `AW = $clog2(DEPTH)`.
- `SYNC_STAGES`, 2: flop stages in the write-pointer synchronizer (≥2).
- `AEMPTY_THRESH`, 4: `almost_empty` asserts when `rd_count <= AEMPTY_THRESH`.

Ports (one clock, `rd_clk`; reset `rd_rst_n` is asynchronous and active-low):
- `rd_clk` in 1: read-domain clock.
- `rd_rst_n` in 1: async active-low reset.
- `wr_ptr_gray` in AW+1: write pointer, Gray code, from the write domain (asynchronous).
- `rd_ptr_gray` out AW+1: registered read pointer, Gray code, to the write-domain synchronizer.
- `rd_ptr` out AW+1: registered binary read pointer, to the memory (low AW bits = address).
- `mem_rd_en` out 1: memory read enable.
- `empty` out 1: registered empty flag, to the memory's empty input and to the consumer.
- `mem_rd_data` in WIDTH: memory read-data register output.
- `dout` out WIDTH: consumer data, equal to `mem_rd_data`.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: consumer accepts `dout`.
- `flush` in 1: discard all words currently visible to the read side.
- `rd_count` out AW+1: registered count of words in memory not yet fetched.
- `almost_empty` out 1: registered, `rd_count <= AEMPTY_THRESH`.

## Operation
- **Synchronizer.** `wr_ptr_gray` passes through `SYNC_STAGES` flops. The last stage is `wq_gray`; `wq_bin` is gray2bin of `wq_gray`.
- **Fetch rule.** `mem_rd_en = ~empty & (~dout_valid | dout_ready) & ~flush`. The memory latches `mem[rd_ptr[AW-1:0]]` on the same edge.
- **Pointer update.** `rd_ptr_next = rd_ptr + mem_rd_en`. `rd_ptr_gray_next = bin2gray(rd_ptr_next)`. Both are registered. Wrap-around is natural modulo 2^(AW+1).
- **Empty flag.** `empty` register takes `(rd_ptr_gray_next == wq_gray)`.
- **Output FSM.** Two states:
  - IDLE (`dout_valid=0`): goes to VALID on `mem_rd_en`.
  - VALID (`dout_valid=1`):
    - `dout_ready & mem_rd_en`: stays in VALID, new word.
    - `dout_ready & ~mem_rd_en`: goes to IDLE.
    - `~dout_ready`: holds, and `dout` stays stable.
- **Count and threshold.** `rd_count` register takes `wq_bin - rd_ptr_next` (AW+1-bit modular, max DEPTH). `almost_empty` register takes `(wq_bin - rd_ptr_next) <= AEMPTY_THRESH`.
- **Flush.** `rd_ptr` loads `wq_bin` and `rd_ptr_gray` loads `wq_gray`. `empty` is set to 1, `dout_valid` to 0, `rd_count` to 0. `mem_rd_en` is forced to 0. Words written after the `wq_gray` sample are kept.
- **Consumer handshake.** `dout_ready` while `dout_valid=0` is ignored. No underflow is possible.

## Timing
- **Reset values:** `rd_ptr=0`, `rd_ptr_gray=0`, all sync flops 0, `empty=1`, `dout_valid=0`, `rd_count=0`, `almost_empty=1`, `mem_rd_en=0`. `dout` is don't-care while `dout_valid=0`.
- **Reset mid-stream:** reset returns all registers to the reset values immediately (asynchronous). The in-flight word is lost. Deassertion is synchronized externally.
- **Write-to-valid latency:** a `wr_ptr_gray` change stable before edge E reaches `wq_gray` at edge E+SYNC_STAGES-1. `empty` falls at E+SYNC_STAGES. `mem_rd_en` is high in the following cycle. `dout_valid` rises at E+SYNC_STAGES+1.
- **Throughput:** one word per `rd_clk` with `dout_ready` held high and `empty=0`.
- **Last word:** when the last visible word is fetched, `empty` rises on the same edge `rd_ptr` advances. `mem_rd_en` never fires on a stale pointer.
- **Simultaneous flush and `dout_ready`:** flush wins and the word is dropped.
- **Simultaneous flush and a sync update:** the value of `wq_gray` before the edge is used.

## Structure
- Package `fifo_pkg`: `bin2gray` and `gray2bin` functions, plus the `AW` derivation. These are shared with the write-side controller.
- Sub-module `ptr_sync`: `SYNC_STAGES`-deep multi-bit flop synchronizer with async active-low reset. It is reused by the write side for `rd_ptr_gray`.

## Test plan
- **Reset:** assert `rd_rst_n=0` mid-stream -> `empty=1`, `dout_valid=0`, `rd_ptr=0`, `rd_count=0`, `almost_empty=1` immediately.
- **Single word:** `wr_ptr_gray` 0 -> 1 (one word, 0xA5) -> `empty` falls 2 edges later, `dout_valid=1` 3 edges later, `dout=0xA5`. After `dout_ready`: `empty=1`, `dout_valid=0`.
- **Streaming:** 32 words with `dout_ready=1` -> one word per cycle, in order. Check `rd_count` 32 -> 0, and `almost_empty` rises when `rd_count` reaches 4.
- **Backpressure:** `dout_ready=0` for 10 cycles with 5 words present -> `dout` stable, `mem_rd_en=0`, `rd_ptr` unchanged. Release gives 5 words back to back.
- **Wrap-around:** run 100 words through DEPTH=32 -> `rd_ptr` wraps 63 -> 0, Gray changes exactly one bit per step, no data loss.
- **Flush:** flush with 7 words pending and `dout_valid=1` -> next edge `rd_ptr=wq_bin`, `empty=1`, `dout_valid=0`, `rd_count=0`. A subsequent write is delivered normally.
